// File: rtl/msg_schedule_stream.sv
// rtl/msg_schedule_stream.sv - streaming SHA-2 message schedule, one word per handshake (optional MSG_SCHEDULE_CHECKSUM_EN)
module msg_schedule_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [16*WORD_W-1:0]  block_in,
    input  logic                  w_ready,
    output logic                  w_valid,
    output logic [WORD_W-1:0]     w_out,
    output logic [IDX_W-1:0]      w_index,
    output logic                  busy,
    output logic                  done
`ifdef MSG_SCHEDULE_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]     checksum
`endif
);

    generate
        if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_illegal_cfg
            $error("msg_schedule_stream: illegal WORD_W/ROUNDS combination");
        end
    endgenerate

    localparam int S0_A = (WORD_W == 64) ? 1  : 7;
    localparam int S0_B = (WORD_W == 64) ? 8  : 18;
    localparam int S0_S = (WORD_W == 64) ? 7  : 3;
    localparam int S1_A = (WORD_W == 64) ? 19 : 17;
    localparam int S1_B = (WORD_W == 64) ? 61 : 19;
    localparam int S1_S = (WORD_W == 64) ? 6  : 10;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_S);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_S);
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   window [16];
    logic [IDX_W-1:0]    t;
    logic                load;
    logic                advance;
    logic                last;
    logic [WORD_W-1:0]   new_word;

    // window[0] is W[t]; the next appended word is W[t+16]
    assign new_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        last       = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        advance = 1'b1;
                        if (t == IDX_W'(ROUNDS - 1)) begin
                            last       = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
            t    <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (abort) begin
                t <= '0;
            end else if (load) begin
                for (int i = 0; i < 16; i++) begin
                    window[i] <= block_in[(16-i)*WORD_W-1 -: WORD_W];
                end
                t <= '0;
            end else if (advance) begin
                for (int i = 0; i < 15; i++) begin
                    window[i] <= window[i+1];
                end
                window[15] <= new_word;
                t          <= last ? '0 : t + IDX_W'(1);
            end
        end
    end

`ifdef MSG_SCHEDULE_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (abort || load) begin
            checksum <= '0;
        end else if (advance) begin
            checksum <= checksum ^ window[0];
        end
    end
`endif

    assign w_valid = (state == RUN);
    assign busy    = (state == RUN);
    assign w_out   = window[0];
    assign w_index = t;

endmodule

// File: doc/msg_schedule_stream.md
Name: msg_schedule_stream

Overview:
- Streaming SHA-2 message-schedule generator. Parametrised successor to the 64-word flat schedule block.
- Accepts one 16-word padded block and emits W[0..ROUNDS-1], one word per valid/ready handshake, to the compression core.
- Holds a 16-word sliding window instead of a flat 2048-bit vector, so it covers SHA-256 (32-bit words) and SHA-512 (64-bit words) from one RTL body.
- Sits between the padder/block buffer and the round engine.

Parameters:
- WORD_W, 32, word width; legal values 32 (SHA-224/256) or 64 (SHA-384/512).
- ROUNDS, 64, number of schedule words emitted; legal values 64 when WORD_W=32, 80 when WORD_W=64.
- IDX_W, $clog2(ROUNDS), width of the w_index output.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  load request; sampled only in IDLE.
- abort  input  1  synchronous abandon of the current block.
- block_in  input  16*WORD_W  padded block; word 0 = bits [16*WORD_W-1 -: WORD_W] (big-endian word order).
- w_ready  input  1  consumer accepts w_out this cycle.
- w_valid  output  1  w_out/w_index valid.
- w_out  output  WORD_W  current schedule word W[t].
- w_index  output  IDX_W  t of the word on w_out.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after W[ROUNDS-1] is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - window, w_out, w_index, checksum = 0.
  - w_valid=0, busy=0, done=0.
- States: IDLE, RUN.
- IDLE + start (abort low):
  - window[i] <= block_in word i, for i=0..15.
  - t <= 0; state <= RUN.
  - w_valid rises the next cycle with W[0], i.e. one cycle load latency.
- RUN:
  - w_valid=1, w_out=window[0], w_index=t, busy=1.
  - Handshake = w_valid & w_ready.
  - On handshake: window shifts down one word (window[i] <= window[i+1]); window[15] <= new_word; t <= t+1.
  - new_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^WORD_W. This equals W[t+16].
  - No handshake: all state holds; w_out and w_index stable while w_valid && !w_ready.
- Sigma functions:
  - WORD_W=32: sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
  - Rotations are true rotations; SHR is a logical shift.
- Last word: handshake with t=ROUNDS-1 → state <= IDLE, w_valid <= 0, done <= 1 for exactly one cycle. Extra window words computed past ROUNDS are discarded.
- Back-to-back: start asserted in the same cycle done is high is accepted (state is already IDLE). Sustained throughput is one word per cycle with w_ready held high.
- start while in RUN: ignored.
- abort: takes priority over start and handshake in any state.
  - Next cycle: state=IDLE, w_valid=0, done=0.
  - window content is don't-care; w_index <= 0.
- reset_n asserted mid-block: immediate return to reset values; no done pulse.
- w_ready asserted while w_valid=0: no effect.
- Illegal WORD_W/ROUNDS combination: elaboration-time error via generate-time check.

Optional Feature:
- Macro: MSG_SCHEDULE_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [WORD_W-1:0] = running XOR of every word accepted since the last start.
  - Cleared to 0 on start acceptance, on abort and on reset.
  - Final value is stable from the done pulse until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- "abc" block, WORD_W=32, window = 0x61626380, 14×0, 0x00000018; w_ready=1:
  - W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB.
  - done pulses one cycle after the index-63 handshake; total 65 cycles from start to done.
- Same block with w_ready toggling 1,0,0,1,…:
  - Identical word sequence; w_out/w_index held on stall cycles; no duplicated or skipped indices.
- WORD_W=64, ROUNDS=80, "abc" SHA-512 padded block (0x6162638000000000, 14×0, 0x18):
  - W[16]=0x6162638000000000.
  - 80 words emitted, last w_index=79, then done.
- abort asserted at t=20 with w_ready=1:
  - Next cycle w_valid=0, busy=0, no done pulse.
  - A subsequent start reloads and restarts at W[0].
- reset_n pulsed low at t=30 asynchronously (between clock edges):
  - Outputs go to 0 immediately without waiting for a clock.
  - start held during reset is ignored.
- start held high throughout RUN, and start in the done cycle:
  - Mid-block start ignored.
  - start in the done cycle begins the next block with W[0] valid the following cycle.
  - With MSG_SCHEDULE_CHECKSUM_EN, checksum equals the XOR of the 64 words of the previous block.
